mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative 64-bit multiply/divide execution unit, directly downstream of the 32x64 register bank.
- Consumes the bank's two read-port operands and produces a result plus a write strobe and destination address that drive the bank's write port (write, address3, input_data).
- Radix-2 with constant latency. A start/busy/done handshake lets the surrounding datapath stall while the unit runs.

Parameters:
- WIDTH, 64, operand and result width in bits.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- op  in  3  operation: 0 MUL (low WIDTH bits), 1 SMULH, 2 UMULH, 3 SDIV, 4 UDIV; 5-7 illegal.
- operand_a  in  WIDTH  multiplicand / dividend (bank output_data1).
- operand_b  in  WIDTH  multiplier / divisor (bank output_data2).
- dest_addr  in  ADDR_W  destination register.
- busy  out  1  high from acceptance until done deasserts.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  registered result, held until the next acceptance.
- wr_en  out  1  equals done; drives bank write.
- wr_addr  out  ADDR_W  captured dest_addr; drives bank address3.

Behaviour:
- Reset (synchronous, dominant over all inputs): state=IDLE, busy=0, done=0, wr_en=0, result=0, wr_addr=0. Reset asserted mid-operation aborts the operation. No done and no write are produced for an aborted operation.
- FSM states: IDLE, PREP, RUN, FIX, DONE.
- IDLE: at a clock edge with start=1, the unit captures op, operand_a, operand_b and dest_addr, then moves to PREP and sets busy=1. Inputs are don't-care afterwards, so the bank may change during the operation.
- PREP (1 cycle):
  - Signed ops: take the absolute value of each operand and record the result sign (SMULH: sign_a XOR sign_b; SDIV: sign_a XOR sign_b).
  - Clear the iteration counter; flag divide-by-zero and illegal op.
- RUN (exactly WIDTH cycles):
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient bits.
  - Counter runs 0..WIDTH-1, then moves to FIX.
- FIX (1 cycle): conditional two's-complement negation of the 2*WIDTH product or of the quotient, then select the output.
  - MUL: low WIDTH bits.
  - SMULH / UMULH: high WIDTH bits.
  - SDIV / UDIV: quotient.
- DONE (1 cycle): done=1, wr_en=1, result valid, busy=1. Next edge goes to IDLE with busy=0. A start in the DONE cycle is ignored.
- Latency is fixed: if start is accepted at edge E0, done is high during the cycle after edge E0+WIDTH+2 (66 cycles for WIDTH=64), for every op including the special cases.
- start while busy=1 is ignored and has no side effects.
- Divide by zero (SDIV or UDIV with operand_b=0): result=0. Full latency is still used.
- SDIV overflow (-2^(WIDTH-1) / -1): result is -2^(WIDTH-1) (0x8000_0000_0000_0000). The wrap arises naturally from the unsigned magnitude path.
- SDIV truncates toward zero.
- Illegal op (5-7): result=0; done and wr_en still pulse at the normal latency; wr_addr=captured dest.
- Only result changes at DONE; result holds its value through IDLE.

Decomposition:
- Shared package holds:
  - op encodings (OP_MUL=0, OP_SMULH=1, OP_UMULH=2, OP_SDIV=3, OP_UDIV=4);
  - the FSM state enum;
  - WIDTH and ADDR_W defaults.
- One sub-module is natural: twos_neg (combinational conditional negate, parameterised width). It is used in PREP for the absolute values and in FIX for the sign correction.
- FSM, counter and shift datapath stay in mul_div_unit.

Test Plan:
- MUL: a=7, b=6, dest=3, start at E0 -> done/wr_en high exactly 66 cycles later; result=42; wr_addr=3; busy low the following cycle.
- UMULH and SMULH:
  - UMULH a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> result=1.
  - SMULH same operands (a = -1) -> result=0xFFFF_FFFF_FFFF_FFFF.
- SDIV a=-7, b=2 -> result=-3 (0xFFFF_FFFF_FFFF_FFFD).
- UDIV a=100, b=7 -> result=14.
- Special cases:
  - UDIV a=100, b=0 -> result=0 at cycle 66.
  - SDIV a=0x8000_0000_0000_0000, b=-1 -> result=0x8000_0000_0000_0000.
  - op=6 -> result=0, wr_en pulses.
- Handshake: start pulse at cycle 10 while busy, with different operands -> no effect on the first result. Change operand_a/b on the cycle after acceptance -> result still uses the captured values.
- Reset mid-operation: assert reset at cycle 30 of a MUL -> next cycle busy=0, result=0; no done or wr_en ever appears. A new start afterwards completes normally with 66-cycle latency.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit_pkg
//  Purpose  : Shared definitions for the iterative multiply/divide unit:
//             default widths, operation encodings and the FSM state type.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mul_div_unit_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_ADDR_W = 5;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_SMULH = 3'd1;
  localparam logic [2:0] OP_UMULH = 3'd2;
  localparam logic [2:0] OP_SDIV  = 3'd3;
  localparam logic [2:0] OP_UDIV  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_twos_neg.sv
`default_nettype none
// ============================================================================
//  Module   : twos_neg
//  Purpose  : Combinational conditional two's-complement negation.
//  Ports    : neg_i  - negate when high, pass through when low
//             val_i  - input value (W bits)
//             val_o  - val_i or -val_i (W bits)
//  Revision : 1.0  initial release
// ============================================================================
module twos_neg
  import mul_div_unit_pkg::*;
#(
  parameter int W = DEF_WIDTH
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Radix-2 iterative 64-bit multiply/divide unit with fixed
//             latency and a start/busy/done handshake. Its result, write
//             strobe and destination address feed a register-bank write port.
//  Ports    : clk, reset       - clock, synchronous active-high reset
//             start            - request, accepted only while idle
//             op               - 0 MUL, 1 SMULH, 2 UMULH, 3 SDIV, 4 UDIV
//             operand_a/_b     - multiplicand/multiplier or dividend/divisor
//             dest_addr        - destination register
//             busy, done       - handshake status (done is a 1-cycle pulse)
//             result           - registered result, updated only at done
//             wr_en, wr_addr   - bank write strobe and address
//  Revision : 1.0  initial release
// ============================================================================
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d;        // captured A; after PREP holds multiplicand or divisor
  logic [WIDTH-1:0]    b_q, b_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;    // {hi, lo}: product, or {remainder, dividend/quotient}
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;    // result sign correction needed in FIX
  logic                zero_q, zero_d;  // divide-by-zero or illegal op forces zero
  logic [WIDTH-1:0]    result_q, result_d;

  logic                w_is_div, w_is_signed;
  logic [WIDTH-1:0]    w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0]  w_fix_in, w_fixed;
  logic [WIDTH:0]      w_mul_sum;
  logic [2*WIDTH-1:0]  w_mul_next;
  logic [WIDTH:0]      w_rem_sh;
  logic [WIDTH+1:0]    w_div_diff;
  logic [2*WIDTH-1:0]  w_div_next;
  logic                w_unused_diff_bit;

  assign w_is_div    = (op_q == OP_SDIV) || (op_q == OP_UDIV);
  assign w_is_signed = (op_q == OP_SMULH) || (op_q == OP_SDIV);

  // Absolute values of the captured operands for signed ops.
  twos_neg #(.W(WIDTH)) u_abs_a (
    .neg_i (w_is_signed & a_q[WIDTH-1]),
    .val_i (a_q),
    .val_o (w_mag_a)
  );

  twos_neg #(.W(WIDTH)) u_abs_b (
    .neg_i (w_is_signed & b_q[WIDTH-1]),
    .val_i (b_q),
    .val_o (w_mag_b)
  );

  // Sign correction: full product for multiplies, quotient only for divides.
  assign w_fix_in = w_is_div ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;

  twos_neg #(.W(2*WIDTH)) u_fix (
    .neg_i (neg_q),
    .val_i (w_fix_in),
    .val_o (w_fixed)
  );

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: shift next dividend bit into the remainder and
  // keep the difference when it does not borrow. The remainder stays below
  // the divisor, so only the low WIDTH bits need to be kept.
  assign w_rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_div_diff = {1'b0, w_rem_sh} - {2'b00, a_q};
  assign w_div_next = w_div_diff[WIDTH+1]
                    ? {w_rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                    : {w_div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign w_unused_diff_bit = w_div_diff[WIDTH];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = operand_a;
          b_d     = operand_b;
          addr_d  = dest_addr;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        a_d     = w_is_div ? w_mag_b : w_mag_a;
        acc_d   = {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
        cnt_d   = '0;
        neg_d   = w_is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        zero_d  = (w_is_div && (b_q == '0)) || (op_q > OP_UDIV);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        acc_d = w_is_div ? w_div_next : w_mul_next;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (zero_q) begin
          result_d = '0;
        end else if ((op_q == OP_MUL) || w_is_div) begin
          result_d = w_fixed[WIDTH-1:0];
        end else begin
          result_d = w_fixed[2*WIDTH-1:WIDTH];
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      addr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      result_q <= result_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign wr_en   = done;
  assign result  = result_q;
  assign wr_addr = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Self-checking bench for mul_div_unit. Expected results are
//             queued when an operation is issued and compared on done.
//  Ports    : none (top-level bench)
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [63:0] operand_a;
  logic [63:0] operand_b;
  logic [4:0]  dest_addr;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        wr_en;
  logic [4:0]  wr_addr;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  addr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(64), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .dest_addr (dest_addr),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic using native wide operators.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]        p;
    logic signed [127:0] sp;
    logic [63:0]         q;
    p  = {64'd0, a} * {64'd0, b};
    sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    q  = '0;
    case (o)
      3'd0: q = p[63:0];
      3'd1: q = sp[127:64];
      3'd2: q = p[127:64];
      3'd3: begin
        if (b == 64'd0) q = '0;
        else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) q = a;
        else q = $signed(a) / $signed(b);
      end
      3'd4: q = (b == 64'd0) ? 64'd0 : a / b;
      default: q = '0;
    endcase
    return q;
  endfunction

  // Issue one operation, scramble the inputs right after acceptance, optionally
  // fire a stray start at cycle 10, then check latency, result and write port.
  task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] d, input logic [63:0] exp_res, input bit glitch);
    int   cyc;
    bit   seen;
    exp_t e;
    @(posedge clk); #1;
    op = o; operand_a = a; operand_b = b; dest_addr = d; start = 1'b1;
    e.res = exp_res; e.addr = d;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = ~a; operand_b = b ^ 64'h5A5A_5A5A_5A5A_5A5A; op = o ^ 3'd1; dest_addr = ~d;
    check("busy_after_accept", 64'(busy), 64'd1);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (glitch && cyc == 10) begin
        start = 1'b1; op = 3'd4; operand_a = 64'd123; operand_b = 64'd5; dest_addr = 5'd30;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("latency", 64'(cyc), 64'd66);
      check("wr_en", 64'(wr_en), 64'd1);
      check("sb_nonempty", 64'(sb_q.size()), 64'd1);
      e = sb_q.pop_front();
      check("result", result, e.res);
      check("wr_addr", 64'(wr_addr), 64'(e.addr));
      @(posedge clk); #1;
      check("busy_after_done", 64'(busy), 64'd0);
      check("done_low", 64'(done), 64'd0);
      check("result_hold", result, e.res);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [63:0] ra, rb;
    int          wr_seen;

    reset = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; dest_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    reset = 1'b0;

    run_op(3'd0, 64'd7, 64'd6, 5'd3, 64'd42, 1'b1);
    run_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, 64'd1, 1'b0);
    run_op(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op(3'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op(3'd4, 64'd100, 64'd7, 5'd7, 64'd14, 1'b0);
    run_op(3'd4, 64'd100, 64'd0, 5'd8, 64'd0, 1'b0);
    run_op(3'd3, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9,
           64'h8000_0000_0000_0000, 1'b0);
    run_op(3'd6, 64'd55, 64'd3, 5'd10, 64'd0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 4));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 3 == 0) rb = rb >> 40;
      run_op(ro, ra, rb, 5'(i + 11), model(ro, ra, rb), 1'b0);
    end

    // Abort a multiply partway through with reset.
    @(posedge clk); #1;
    op = 3'd0; operand_a = 64'd1234; operand_b = 64'd5678; dest_addr = 5'd21; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_wr_addr", 64'(wr_addr), 64'd0);
    wr_seen = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (wr_en || done) wr_seen++;
    end
    check("abort_no_write", 64'(wr_seen), 64'd0);

    run_op(3'd0, 64'd9, 64'd9, 5'd12, 64'd81, 1'b0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
